// File: rtl/gcd_lcm_if.sv
// Request/response bundle between the register wrapper and gcd_lcm_engine.
`timescale 1ns/1ps
interface gcd_lcm_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic                 start;
  logic                 mode;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   result;
  logic [CNT_W-1:0]     cycles;

  modport master (
    output start, mode, a, b,
    input  busy, done, result, cycles
  );

  modport slave (
    input  start, mode, a, b,
    output busy, done, result, cycles
  );
endinterface

// File: rtl/gcd_lcm_engine.sv
// Multi-cycle binary GCD engine with optional LCM via
// restoring divide and shift-add multiply.
`timescale 1ns/1ps
module gcd_lcm_engine #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic      clk,
  input  logic      RST,
  gcd_lcm_if.slave  bus
);

  localparam int KW = $clog2(WIDTH) + 1;
  localparam int SW = $clog2(WIDTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_STRIP  = 3'd1;
  localparam logic [2:0] S_REDUCE = 3'd2;
  localparam logic [2:0] S_DIV    = 3'd3;
  localparam logic [2:0] S_MUL    = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [SW-1:0] LAST_STEP = SW'(WIDTH - 1);

  logic [2:0]         state_q,  state_d;
  logic [WIDTH-1:0]   a_q,      a_d;
  logic [WIDTH-1:0]   b_q,      b_d;
  logic               mode_q,   mode_d;
  logic [WIDTH-1:0]   u_q,      u_d;
  logic [WIDTH-1:0]   v_q,      v_d;
  logic [KW-1:0]      k_q,      k_d;
  logic [WIDTH-1:0]   g_q,      g_d;
  logic [WIDTH-1:0]   rem_q,    rem_d;
  logic [WIDTH-1:0]   quo_q,    quo_d;
  logic [2*WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q,    acc_d;
  logic [SW-1:0]      step_q,   step_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               busy_q,   busy_d;
  logic               done_q,   done_d;
  logic [CNT_W-1:0]   cycles_q, cycles_d;

  logic [CNT_W-1:0]   cnt_inc;
  logic [WIDTH-1:0]   g_nx;
  logic [WIDTH-1:0]   rem_lo;
  logic               rem_ge;
  logic [WIDTH-1:0]   quo_nx;
  logic [2*WIDTH-1:0] prod_nx;

  always_comb begin
    cnt_inc = (cycles_q == {CNT_W{1'b1}}) ? cycles_q
                                          : cycles_q + 1'b1;
    g_nx    = u_q << k_q;
    // The shifted-out remainder MSB means the partial
    // remainder already exceeds any WIDTH-bit divisor.
    rem_lo  = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
    rem_ge  = rem_q[WIDTH-1] | (rem_lo >= g_q);
    quo_nx  = {quo_q[WIDTH-2:0], rem_ge};
    prod_nx = acc_q + (mplier_q[0] ? mcand_q
                                   : {2*WIDTH{1'b0}});
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    mode_d   = mode_q;
    u_d      = u_q;
    v_d      = v_q;
    k_d      = k_q;
    g_d      = g_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    step_d   = step_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = done_q;
    cycles_d = cycles_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          a_d      = bus.a;
          b_d      = bus.b;
          mode_d   = bus.mode;
          cycles_d = CNT_W'(1);
          done_d   = 1'b0;
          if (bus.a == '0 || bus.b == '0) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            result_d = bus.mode ? {2*WIDTH{1'b0}}
                     : {{WIDTH{1'b0}}, bus.a | bus.b};
          end else begin
            state_d = S_STRIP;
            busy_d  = 1'b1;
            u_d     = bus.a;
            v_d     = bus.b;
            k_d     = '0;
          end
        end
      end

      S_STRIP: begin
        cycles_d = cnt_inc;
        if (!u_q[0] && !v_q[0]) begin
          u_d = u_q >> 1;
          v_d = v_q >> 1;
          k_d = k_q + 1'b1;
        end else begin
          state_d = S_REDUCE;
        end
      end

      S_REDUCE: begin
        cycles_d = cnt_inc;
        if (u_q == v_q) begin
          g_d = g_nx;
          if (mode_q) begin
            state_d = S_DIV;
            rem_d   = '0;
            quo_d   = a_q;
            step_d  = '0;
          end else begin
            state_d  = S_DONE;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            result_d = {{WIDTH{1'b0}}, g_nx};
          end
        end else if (!u_q[0]) begin
          u_d = u_q >> 1;
        end else if (!v_q[0]) begin
          v_d = v_q >> 1;
        end else if (u_q > v_q) begin
          u_d = (u_q - v_q) >> 1;
        end else begin
          v_d = (v_q - u_q) >> 1;
        end
      end

      S_DIV: begin
        cycles_d = cnt_inc;
        rem_d    = rem_ge ? rem_lo - g_q : rem_lo;
        quo_d    = quo_nx;
        step_d   = step_q + 1'b1;
        if (step_q == LAST_STEP) begin
          state_d  = S_MUL;
          mcand_d  = {{WIDTH{1'b0}}, quo_nx};
          mplier_d = b_q;
          acc_d    = '0;
          step_d   = '0;
        end
      end

      S_MUL: begin
        cycles_d = cnt_inc;
        acc_d    = prod_nx;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        step_d   = step_q + 1'b1;
        if (step_q == LAST_STEP) begin
          state_d  = S_DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          result_d = prod_nx;
          step_d   = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= 1'b0;
      u_q      <= '0;
      v_q      <= '0;
      k_q      <= '0;
      g_q      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      step_q   <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mode_q   <= mode_d;
      u_q      <= u_d;
      v_q      <= v_d;
      k_q      <= k_d;
      g_q      <= g_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      step_q   <= step_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cycles_q <= cycles_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.cycles = cycles_q;

endmodule

// File: tb/tb_gcd_lcm_engine.sv
// Bench for gcd_lcm_engine: directed cases plus random
// pairs against an Euclid-based reference model.
`timescale 1ns/1ps
module tb_gcd_lcm_engine;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gcd_lcm_if #(.WIDTH(32), .CNT_W(16)) b32 ();
  gcd_lcm_if #(.WIDTH(8),  .CNT_W(16)) b8 ();

  gcd_lcm_engine #(.WIDTH(32), .CNT_W(16)) dut32 (
    .clk (clk),
    .RST (rst),
    .bus (b32)
  );

  gcd_lcm_engine #(.WIDTH(8), .CNT_W(16)) dut8 (
    .clk (clk),
    .RST (rst),
    .bus (b8)
  );

  int errors = 0;
  int checks = 0;

  function automatic longint unsigned gcd_ref(
    input longint unsigned x, input longint unsigned y);
    longint unsigned t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic longint unsigned lcm_ref(
    input longint unsigned x, input longint unsigned y);
    if (x == 0 || y == 0) return 0;
    return (x / gcd_ref(x, y)) * y;
  endfunction

  function automatic longint unsigned ref_of(
    input logic m, input longint unsigned x,
    input longint unsigned y);
    return m ? lcm_ref(x, y) : gcd_ref(x, y);
  endfunction

  task automatic go32(input logic m, input logic [31:0] x,
                      input logic [31:0] y, output bit to);
    @(posedge clk); #1;
    b32.start = 1'b1; b32.mode = m; b32.a = x; b32.b = y;
    @(posedge clk); #1;
    b32.start = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (b32.done) begin to = 1'b0; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic go8(input logic m, input logic [7:0] x,
                     input logic [7:0] y, output bit to);
    @(posedge clk); #1;
    b8.start = 1'b1; b8.mode = m; b8.a = x; b8.b = y;
    @(posedge clk); #1;
    b8.start = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (b8.done) begin to = 1'b0; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (b32.busy !== 1'b0 || b32.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags busy=%b done=%b want 0 0",
               b32.busy, b32.done);
    end
    checks++;
    if (b32.result !== 64'd0 || b32.cycles !== 16'd0) begin
      errors++;
      $display("FAIL reset_data result=%h cycles=%0d want 0",
               b32.result, b32.cycles);
    end
    checks++;
    if (b8.busy !== 1'b0 || b8.done !== 1'b0 ||
        b8.result !== 16'd0 || b8.cycles !== 16'd0) begin
      errors++;
      $display("FAIL reset_w8 busy=%b done=%b res=%h cyc=%0d",
               b8.busy, b8.done, b8.result, b8.cycles);
    end
    rst = 1'b0;
  endtask

  task automatic test_gcd_basic;
    bit to;
    int gcyc;
    go32(1'b0, 32'd12, 32'd18, to);
    checks++;
    if (to || b32.result !== 64'd6 || b32.busy !== 1'b0) begin
      errors++;
      $display("FAIL gcd_12_18 result=%0d busy=%b to=%b want 6",
               b32.result, b32.busy, to);
    end
    checks++;
    if (b32.cycles > 16'd66 || b32.cycles == 16'd0) begin
      errors++;
      $display("FAIL gcd_12_18_cyc cycles=%0d want 1..66",
               b32.cycles);
    end
    gcyc = int'(b32.cycles);
    go32(1'b1, 32'd12, 32'd18, to);
    checks++;
    if (to || b32.result !== 64'd36) begin
      errors++;
      $display("FAIL lcm_12_18 result=%0d want 36", b32.result);
    end
    checks++;
    if (int'(b32.cycles) !== gcyc + 64) begin
      errors++;
      $display("FAIL lcm_12_18_cyc cycles=%0d want %0d",
               b32.cycles, gcyc + 64);
    end
  endtask

  task automatic test_lcm_48_180;
    bit to;
    logic [31:0] ops [2][2];
    ops[0][0] = 32'd48;  ops[0][1] = 32'd180;
    ops[1][0] = 32'd180; ops[1][1] = 32'd48;
    for (int s = 0; s < 2; s++) begin
      go32(1'b1, ops[s][0], ops[s][1], to);
      checks++;
      if (to || b32.result !== 64'd720) begin
        errors++;
        $display("FAIL lcm_48_180[%0d] result=%0d want 720",
                 s, b32.result);
      end
      go32(1'b0, ops[s][0], ops[s][1], to);
      checks++;
      if (to || b32.result !== 64'd12) begin
        errors++;
        $display("FAIL gcd_48_180[%0d] result=%0d want 12",
                 s, b32.result);
      end
    end
  endtask

  task automatic test_zero;
    bit to;
    logic        zm [4];
    logic [31:0] za [4];
    logic [31:0] zb [4];
    logic [63:0] zr [4];
    zm[0] = 0; za[0] = 0; zb[0] = 7; zr[0] = 7;
    zm[1] = 0; za[1] = 7; zb[1] = 0; zr[1] = 7;
    zm[2] = 0; za[2] = 0; zb[2] = 0; zr[2] = 0;
    zm[3] = 1; za[3] = 0; zb[3] = 7; zr[3] = 0;
    for (int i = 0; i < 4; i++) begin
      go32(zm[i], za[i], zb[i], to);
      checks++;
      if (to || b32.result !== zr[i] || b32.cycles !== 16'd1
          || b32.busy !== 1'b0) begin
        errors++;
        $display("FAIL zero[%0d] result=%0d cycles=%0d busy=%b want %0d 1 0",
                 i, b32.result, b32.cycles, b32.busy, zr[i]);
      end
    end
  endtask

  task automatic test_large;
    bit to;
    go32(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, to);
    checks++;
    if (to || b32.result !== 64'hFFFF_FFFD_0000_0002) begin
      errors++;
      $display("FAIL lcm_max result=%h want fffffffd00000002",
               b32.result);
    end
    go32(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, to);
    checks++;
    if (to || b32.result !== 64'd1) begin
      errors++;
      $display("FAIL gcd_max result=%h want 1", b32.result);
    end
    go32(1'b0, 32'h8000_0000, 32'h8000_0000, to);
    checks++;
    if (to || b32.result !== 64'h8000_0000
        || b32.cycles !== 16'd34) begin
      errors++;
      $display("FAIL gcd_pow2 result=%h cycles=%0d want 80000000 34",
               b32.result, b32.cycles);
    end
    go32(1'b1, 32'h8000_0000, 32'h8000_0000, to);
    checks++;
    if (to || b32.result !== 64'h8000_0000
        || b32.cycles !== 16'd98) begin
      errors++;
      $display("FAIL lcm_pow2 result=%h cycles=%0d want 80000000 98",
               b32.result, b32.cycles);
    end
  endtask

  task automatic test_busy_ignore;
    bit to;
    @(posedge clk); #1;
    b32.start = 1'b1; b32.mode = 1'b0;
    b32.a = 32'd12; b32.b = 32'd18;
    @(posedge clk); #1;
    b32.a = 32'd5; b32.b = 32'd10;
    checks++;
    if (b32.busy !== 1'b1 || b32.done !== 1'b0) begin
      errors++;
      $display("FAIL accept_flags busy=%b done=%b want 1 0",
               b32.busy, b32.done);
    end
    repeat (2) @(posedge clk);
    #1;
    b32.start = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (b32.done) begin to = 1'b0; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (to || b32.result !== 64'd6) begin
      errors++;
      $display("FAIL busy_ignore result=%0d want 6", b32.result);
    end
  endtask

  task automatic test_start_in_done;
    bit to;
    @(posedge clk); #1;
    b32.start = 1'b1; b32.mode = 1'b0;
    b32.a = 32'd5; b32.b = 32'd10;
    @(posedge clk); #1;
    b32.start = 1'b0;
    checks++;
    if (b32.done !== 1'b0 || b32.busy !== 1'b1
        || b32.cycles !== 16'd1) begin
      errors++;
      $display("FAIL done_restart done=%b busy=%b cyc=%0d want 0 1 1",
               b32.done, b32.busy, b32.cycles);
    end
    to = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (b32.done) begin to = 1'b0; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (to || b32.result !== 64'd5) begin
      errors++;
      $display("FAIL done_restart_res result=%0d want 5",
               b32.result);
    end
  endtask

  task automatic test_back_to_back;
    int pulses, run, maxrun;
    pulses = 0; run = 0; maxrun = 0;
    @(posedge clk); #1;
    b32.start = 1'b1; b32.mode = 1'b0;
    b32.a = 32'd12; b32.b = 32'd18;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (b32.done) begin
        if (run == 0) pulses++;
        run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
    end
    b32.start = 1'b0;
    checks++;
    if (pulses < 5 || maxrun != 1) begin
      errors++;
      $display("FAIL back_to_back pulses=%0d maxrun=%0d want >=5 1",
               pulses, maxrun);
    end
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (b32.done !== 1'b1 || b32.result !== 64'd6) begin
      errors++;
      $display("FAIL b2b_final done=%b result=%0d want 1 6",
               b32.done, b32.result);
    end
  endtask

  task automatic test_reset_mid;
    bit seen;
    @(posedge clk); #1;
    b32.start = 1'b1; b32.mode = 1'b0;
    b32.a = 32'hFFFF_FFFF; b32.b = 32'd1;
    @(posedge clk); #1;
    b32.start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (b32.busy !== 1'b0 || b32.done !== 1'b0 ||
        b32.result !== 64'd0 || b32.cycles !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid busy=%b done=%b res=%h cyc=%0d want 0",
               b32.busy, b32.done, b32.result, b32.cycles);
    end
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (b32.done) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_nodone done_seen=%b want 0", seen);
    end
  endtask

  task automatic test_random32;
    bit to;
    logic [31:0] x, y;
    logic        m;
    longint unsigned exp;
    for (int i = 0; i < 30; i++) begin
      x = $urandom;
      y = $urandom;
      if (i % 3 == 0) x = x & 32'hFFF0_0000;
      if (i % 5 == 0) y = y << (i % 17);
      m = 1'(i & 1);
      exp = ref_of(m, longint'(x), longint'(y));
      go32(m, x, y, to);
      checks++;
      if (to || b32.result !== 64'(exp)) begin
        errors++;
        $display("FAIL rand32 m=%b a=%h b=%h result=%h want %h",
                 m, x, y, b32.result, exp);
      end
      if (!m) begin
        checks++;
        if (b32.cycles > 16'd66) begin
          errors++;
          $display("FAIL rand32_lat a=%h b=%h cycles=%0d want <=66",
                   x, y, b32.cycles);
        end
      end
    end
  endtask

  task automatic test_w8_regress;
    bit to;
    logic [7:0] x, y;
    logic       m;
    longint unsigned exp;
    int bad;
    bad = 0;
    for (int i = 0; i < 320; i++) begin
      x = 8'($urandom_range(0, 255));
      y = 8'($urandom_range(0, 255));
      if (i < 16) begin
        x = (i % 4 == 0) ? 8'd0 : (i % 4 == 1) ? 8'd255
          : (i % 4 == 2) ? 8'd128 : 8'd1;
        y = (i / 4 == 0) ? 8'd0 : (i / 4 == 1) ? 8'd255
          : (i / 4 == 2) ? 8'd128 : 8'd1;
      end
      m = 1'($urandom_range(0, 1));
      exp = ref_of(m, longint'(x), longint'(y));
      go8(m, x, y, to);
      checks++;
      if (to || b8.result !== 16'(exp)) begin
        errors++;
        bad++;
        if (bad < 10)
          $display("FAIL w8 m=%b a=%0d b=%0d result=%0d want %0d",
                   m, x, y, b8.result, exp);
      end
      checks++;
      if (b8.cycles > (m ? 16'd34 : 16'd18)) begin
        errors++;
        $display("FAIL w8_lat m=%b a=%0d b=%0d cycles=%0d",
                 m, x, y, b8.cycles);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    b32.start = 1'b0; b32.mode = 1'b0;
    b32.a = '0; b32.b = '0;
    b8.start = 1'b0; b8.mode = 1'b0;
    b8.a = '0; b8.b = '0;
    test_reset();
    test_gcd_basic();
    test_lcm_48_180();
    test_zero();
    test_large();
    test_busy_ignore();
    test_start_in_done();
    test_back_to_back();
    test_reset_mid();
    test_random32();
    test_w8_regress();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
